// File: rtl/measdif_axil_arb_if.sv
// AXI4-Lite master-side bus bundle between the arbiter and the measdif register slave.
interface measdif_axil_arb_if #(
  parameter int unsigned C_ADDR_WIDTH = 4,
  parameter int unsigned C_DATA_WIDTH = 32
);

  localparam int unsigned AW = C_ADDR_WIDTH;
  localparam int unsigned DW = C_DATA_WIDTH;
  localparam int unsigned SW = C_DATA_WIDTH / 8;

  // write address channel
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;

  // write data channel
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid;
  logic          wready;

  // write response channel
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;

  // read address channel
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;

  // read data channel
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/measdif_axil_arb.sv
// Two-requester round-robin arbiter that turns single-word register requests
// into complete AXI4-Lite transactions towards the measdif register slave.
// Only a 32-bit data path is meaningful for the slave behind this block.
module measdif_axil_arb #(
  parameter int unsigned C_ADDR_WIDTH = 4,
  parameter int unsigned C_DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,

  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [C_ADDR_WIDTH-1:0] m0_addr,
  input  logic [C_DATA_WIDTH-1:0] m0_wdata,
  output logic                    m0_ack,
  output logic [C_DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]              m0_resp,

  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [C_ADDR_WIDTH-1:0] m1_addr,
  input  logic [C_DATA_WIDTH-1:0] m1_wdata,
  output logic                    m1_ack,
  output logic [C_DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]              m1_resp,

  measdif_axil_arb_if.master      m_axi
);

  localparam int unsigned AW = C_ADDR_WIDTH;
  localparam int unsigned DW = C_DATA_WIDTH;
  localparam int unsigned SW = C_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RD_A  = 3'd3,
    S_RD_D  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  // registered AXI outputs
  logic [AW-1:0] awaddr_q,  awaddr_d;
  logic [AW-1:0] araddr_q,  araddr_d;
  logic [DW-1:0] wdata_q,   wdata_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q,  wvalid_d;
  logic          bready_q,  bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q,  rready_d;

  // registered requester outputs
  logic          m0_ack_q,   m0_ack_d;
  logic          m1_ack_q,   m1_ack_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic [1:0]    m0_resp_q,  m0_resp_d;
  logic [1:0]    m1_resp_q,  m1_resp_d;

  // arbitration bookkeeping
  logic          grant_id_q,   grant_id_d;
  logic          last_grant_q, last_grant_d;

  // arbitration choice and selected request fields
  logic          any_req_c;
  logic          sel_c;
  logic          sel_we_c;
  logic [AW-1:0] sel_addr_c;
  logic [AW-1:0] sel_addr_aligned_c;
  logic [DW-1:0] sel_wdata_c;

  // channel handshakes and per-channel completion in WR
  logic          aw_hs_c;
  logic          w_hs_c;
  logic          b_hs_c;
  logic          ar_hs_c;
  logic          r_hs_c;
  logic          aw_ok_c;
  logic          w_ok_c;

  // round-robin pick: a sole requester wins, a tie goes to the one not served last
  always_comb begin
    any_req_c = m0_req | m1_req;
    if (m0_req && m1_req) begin
      sel_c = ~last_grant_q;
    end else begin
      sel_c = m1_req;
    end
    sel_we_c           = sel_c ? m1_we    : m0_we;
    sel_addr_c         = sel_c ? m1_addr  : m0_addr;
    sel_wdata_c        = sel_c ? m1_wdata : m0_wdata;
    sel_addr_aligned_c = sel_addr_c & ~AW'(3);
  end

  // handshakes are only ever counted while this block itself drives VALID/READY
  always_comb begin
    aw_hs_c = awvalid_q & m_axi.awready;
    w_hs_c  = wvalid_q  & m_axi.wready;
    b_hs_c  = bready_q  & m_axi.bvalid;
    ar_hs_c = arvalid_q & m_axi.arready;
    r_hs_c  = rready_q  & m_axi.rvalid;
    aw_ok_c = ~awvalid_q | aw_hs_c;
    w_ok_c  = ~wvalid_q  | w_hs_c;
  end

  // state register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (any_req_c) begin
          state_next = sel_we_c ? S_WR : S_RD_A;
        end
      end
      S_WR: begin
        if (aw_ok_c && w_ok_c) begin
          state_next = S_WRESP;
        end
      end
      S_WRESP: begin
        if (b_hs_c) begin
          state_next = S_DONE;
        end
      end
      S_RD_A: begin
        if (ar_hs_c) begin
          state_next = S_RD_D;
        end
      end
      S_RD_D: begin
        if (r_hs_c) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // next values of every registered output; ack is a pulse, everything else holds
  always_comb begin
    awaddr_d     = awaddr_q;
    araddr_d     = araddr_q;
    wdata_d      = wdata_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    m0_resp_d    = m0_resp_q;
    m1_resp_d    = m1_resp_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;

    case (state)
      S_IDLE: begin
        if (any_req_c) begin
          grant_id_d = sel_c;
          awaddr_d   = sel_addr_aligned_c;
          araddr_d   = sel_addr_aligned_c;
          wdata_d    = sel_wdata_c;
          if (sel_we_c) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR: begin
        if (aw_hs_c) begin
          awvalid_d = 1'b0;
        end
        if (w_hs_c) begin
          wvalid_d = 1'b0;
        end
        if (state_next == S_WRESP) begin
          bready_d = 1'b1;
        end
      end
      S_WRESP: begin
        if (b_hs_c) begin
          bready_d = 1'b0;
          if (grant_id_q) begin
            m1_ack_d  = 1'b1;
            m1_resp_d = m_axi.bresp;
          end else begin
            m0_ack_d  = 1'b1;
            m0_resp_d = m_axi.bresp;
          end
        end
      end
      S_RD_A: begin
        if (ar_hs_c) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_RD_D: begin
        if (r_hs_c) begin
          rready_d = 1'b0;
          if (grant_id_q) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = m_axi.rdata;
            m1_resp_d  = m_axi.rresp;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = m_axi.rdata;
            m0_resp_d  = m_axi.rresp;
          end
        end
      end
      S_DONE: begin
        last_grant_d = grant_id_q;
      end
      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  // output registers; reset abandons any transaction in flight
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_resp_q    <= 2'b00;
      m1_resp_q    <= 2'b00;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      awaddr_q     <= awaddr_d;
      araddr_q     <= araddr_d;
      wdata_q      <= wdata_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_resp_q    <= m0_resp_d;
      m1_resp_q    <= m1_resp_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // AXI master outputs
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = {SW{1'b1}};
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  // requester outputs
  assign m0_ack   = m0_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m0_resp  = m0_resp_q;
  assign m1_ack   = m1_ack_q;
  assign m1_rdata = m1_rdata_q;
  assign m1_resp  = m1_resp_q;

endmodule

// File: tb/tb_measdif_axil_arb.sv
// Directed bench for measdif_axil_arb with a small behavioural AXI4-Lite register slave.
module tb_measdif_axil_arb;

  logic        clk;
  logic        ARESET;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_resp, m1_resp;

  measdif_axil_arb_if #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) axi ();

  measdif_axil_arb #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
    .ACLK     (clk),
    .ARESET   (ARESET),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m0_resp  (m0_resp),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .m1_resp  (m1_resp),
    .m_axi    (axi.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // single comparison point for the whole bench
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // behavioural slave state and knobs
  logic [31:0] mem [4];
  int          cfg_aw_wait = 0;
  int          cfg_w_wait  = 0;
  int          cfg_ar_wait = 0;
  logic [1:0]  cfg_resp    = 2'b00;
  bit          r_hold      = 1'b0;
  bit          slave_clr   = 1'b0;
  bit          aw_seen = 0, w_seen = 0, ar_seen = 0;
  bit          b_hs = 0, r_hs = 0;
  int          aw_ctr = 0, w_ctr = 0, ar_ctr = 0;
  logic [3:0]  cap_awaddr = '0, cap_araddr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  int          awv_cycles = 0, wv_cycles = 0, m0_acks = 0, m1_acks = 0;

  // slave: observe handshakes at the rising edge, drive responses at the falling edge
  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rresp = 0; axi.rdata = '0;
    forever begin
      @(posedge clk);
      if (axi.awvalid && axi.awready) begin aw_seen = 1; cap_awaddr = axi.awaddr; end
      if (axi.wvalid && axi.wready) begin w_seen = 1; cap_wdata = axi.wdata; cap_wstrb = axi.wstrb; end
      if (axi.arvalid && axi.arready) begin ar_seen = 1; cap_araddr = axi.araddr; end
      b_hs = axi.bvalid && axi.bready;
      r_hs = axi.rvalid && axi.rready;
      if (axi.awvalid) awv_cycles++;
      if (axi.wvalid) wv_cycles++;
      if (m0_ack) m0_acks++;
      if (m1_ack) m1_acks++;
      @(negedge clk);
      if (slave_clr) begin
        aw_seen = 0; w_seen = 0; ar_seen = 0; r_hold = 0; slave_clr = 0;
        axi.bvalid = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.arready = 0;
        aw_ctr = 0; w_ctr = 0; ar_ctr = 0;
      end else begin
        if (b_hs) axi.bvalid = 0;
        if (r_hs) axi.rvalid = 0;
        if (axi.awvalid === 1'b1) begin
          if (aw_ctr >= cfg_aw_wait) axi.awready = 1; else begin axi.awready = 0; aw_ctr++; end
        end else begin axi.awready = 0; aw_ctr = 0; end
        if (axi.wvalid === 1'b1) begin
          if (w_ctr >= cfg_w_wait) axi.wready = 1; else begin axi.wready = 0; w_ctr++; end
        end else begin axi.wready = 0; w_ctr = 0; end
        if (axi.arvalid === 1'b1) begin
          if (ar_ctr >= cfg_ar_wait) axi.arready = 1; else begin axi.arready = 0; ar_ctr++; end
        end else begin axi.arready = 0; ar_ctr = 0; end
        if (aw_seen && w_seen && !axi.bvalid) begin
          axi.bvalid = 1; axi.bresp = cfg_resp;
          if (cfg_resp == 2'b00) mem[cap_awaddr[3:2]] = cap_wdata;
          aw_seen = 0; w_seen = 0;
        end
        if (ar_seen && !axi.rvalid && !r_hold) begin
          axi.rvalid = 1; axi.rdata = mem[cap_araddr[3:2]]; axi.rresp = cfg_resp;
          ar_seen = 0;
        end
      end
    end
  end

  // reset pulse; returns at a falling edge with reset released
  task automatic do_reset();
    @(negedge clk);
    ARESET = 1;
    m0_req = 0; m1_req = 0;
    repeat (2) @(negedge clk);
    ARESET = 0;
  endtask

  // one request; lat = falling edges from grant edge to ack (999 if none)
  task automatic txn(input bit port, input bit we, input logic [3:0] addr,
                     input logic [31:0] wdata, output int lat);
    if (!port) begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
    else       begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
    @(posedge clk);
    @(negedge clk);
    if (!port) begin m0_req = 0; m0_we = ~we; m0_addr = ~addr; m0_wdata = ~wdata; end
    else       begin m1_req = 0; m1_we = ~we; m1_addr = ~addr; m1_wdata = ~wdata; end
    lat = 1;
    while (lat <= 60 && !(port ? m1_ack : m0_ack)) begin
      @(negedge clk);
      lat++;
    end
    if (lat > 60) lat = 999;
  endtask

  // the cycle after an ack both acks must be low again
  task automatic after_ack(input string tag);
    @(negedge clk);
    chk(tag, {62'd0, m0_ack, m1_ack}, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int lat;
  int order [4];
  int when  [4];
  int n;
  int acks_before;

  initial begin
    ARESET = 1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    do_reset();

    // reset state
    chk("rst_valids", {59'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 64'd0);
    chk("rst_acks", {62'd0, m0_ack, m1_ack}, 64'd0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
    chk("rst_resp", {60'd0, m0_resp, m1_resp}, 64'd0);
    chk("rst_addr", {56'd0, axi.awaddr, axi.araddr}, 64'd0);
    chk("rst_wdata", {32'd0, axi.wdata}, 64'd0);

    // single write from m0, zero-wait slave
    txn(0, 1, 4'h4, 32'hDEADBEEF, lat);
    chk("wr_latency", lat, 3);
    chk("wr_resp", m0_resp, 2'b00);
    chk("wr_awaddr", cap_awaddr, 4'h4);
    chk("wr_wdata", cap_wdata, 32'hDEADBEEF);
    chk("wr_wstrb", cap_wstrb, 4'hF);
    chk("wr_prot", {axi.awprot, axi.arprot}, 6'd0);
    after_ack("wr_ack_pulse");
    chk("wr_m1_quiet", m1_acks, 0);
    chk("wr_m0_once", m0_acks, 1);

    // read-back paths
    txn(0, 0, 4'h4, 32'h0, lat);
    chk("rd0_latency", lat, 3);
    chk("rd0_rdata", m0_rdata, 32'hDEADBEEF);
    after_ack("rd0_ack_pulse");
    txn(1, 1, 4'h8, 32'h00000003, lat);
    chk("wr1_latency", lat, 3);
    chk("wr1_rdata_kept", m1_rdata, 32'h0);
    after_ack("wr1_ack_pulse");
    txn(1, 0, 4'h8, 32'h0, lat);
    chk("rd1_latency", lat, 3);
    chk("rd1_araddr", cap_araddr, 4'h8);
    chk("rd1_rdata", m1_rdata, 32'h00000003);
    chk("rd1_m0_kept", m0_rdata, 32'hDEADBEEF);
    after_ack("rd1_ack_pulse");

    // contention from reset: both requesters held high for four transactions
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 4'h4;
    m1_req = 1; m1_we = 0; m1_addr = 4'h8;
    n = 0;
    for (int c = 1; c <= 60 && n < 4; c++) begin
      @(negedge clk);
      if (m0_ack && n < 4) begin order[n] = 0; when[n] = c; n++; end
      if (m1_ack && n < 4) begin order[n] = 1; when[n] = c; n++; end
    end
    m0_req = 0; m1_req = 0;
    chk("rr_count", n, 4);
    chk("rr_order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0101);
    chk("rr_first", when[0], 3);
    chk("rr_gap1", when[1] - when[0], 4);
    chk("rr_gap2", when[2] - when[1], 4);
    chk("rr_gap3", when[3] - when[2], 4);
    chk("rr_rdata", {m0_rdata, m1_rdata}, {32'hDEADBEEF, 32'h00000003});
    after_ack("rr_ack_pulse");

    // independent AW/W handshakes: AWREADY late, WREADY immediate
    repeat (2) @(negedge clk);
    cfg_aw_wait = 3;
    awv_cycles = 0; wv_cycles = 0; acks_before = m0_acks + m1_acks;
    txn(0, 1, 4'hC, 32'hCAFEF00D, lat);
    chk("aww_latency", lat, 6);
    after_ack("aww_ack_pulse");
    chk("aww_awvalid_cycles", awv_cycles, 4);
    chk("aww_wvalid_cycles", wv_cycles, 1);
    chk("aww_single_ack", m0_acks + m1_acks - acks_before, 1);
    chk("aww_awaddr", cap_awaddr, 4'hC);
    cfg_aw_wait = 0;

    // error response on an unaligned read, then an immediate follow-up
    cfg_resp = 2'b10;
    txn(1, 0, 4'h6, 32'h0, lat);
    chk("err_latency", lat, 3);
    chk("err_araddr", cap_araddr, 4'h4);
    chk("err_resp", m1_resp, 2'b10);
    chk("err_rdata", m1_rdata, 32'hDEADBEEF);
    after_ack("err_ack_pulse");
    cfg_resp = 2'b00;
    txn(0, 0, 4'hC, 32'h0, lat);
    chk("err_next_latency", lat, 3);
    chk("err_next_rdata", m0_rdata, 32'hCAFEF00D);
    chk("err_next_resp", m0_resp, 2'b00);
    after_ack("err_next_ack_pulse");

    // reset while waiting for read data
    r_hold = 1;
    m0_req = 1; m0_we = 0; m0_addr = 4'h4;
    @(posedge clk);
    @(negedge clk);
    m0_req = 0;
    n = 0;
    while (n < 20 && axi.rready !== 1'b1) begin @(negedge clk); n++; end
    chk("mid_reach_rd_d", axi.rready, 1'b1);
    acks_before = m0_acks + m1_acks;
    ARESET = 1;
    @(negedge clk);
    chk("mid_rready", axi.rready, 1'b0);
    chk("mid_arvalid", axi.arvalid, 1'b0);
    ARESET = 0;
    slave_clr = 1;
    repeat (5) begin
      @(negedge clk);
      if (m0_ack || m1_ack) n = 99;
    end
    chk("mid_no_ack", m0_acks + m1_acks - acks_before, 0);
    txn(0, 0, 4'h8, 32'h0, lat);
    chk("mid_new_latency", lat, 3);
    chk("mid_new_rdata", m0_rdata, 32'h00000003);
    after_ack("mid_new_ack_pulse");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
